// File: rtl/weight_load_receiver.sv
// weight_load_receiver: receiving end of the weight-load stream.
// Decodes layer + flat address into three per-layer weight RAMs (hidden1,
// hidden2, output), tracks in-order layer completion, flags protocol errors
// and serves a 1-cycle-latency read port to the datapath.
// Optional feature: define WEIGHT_RX_CHECKSUM_EN to add o_checksum, a running
// XOR of every accepted word since the last load start.
module weight_load_receiver #(
  parameter int DATA_WIDTH                    = 32,
  parameter int LAYER_WIDTH                   = 2,
  parameter int WEIGHT_COUNTER_WIDTH          = 11,
  parameter int NUMBER_OF_INPUT_NODE          = 2,
  parameter int NUMBER_OF_HIDDEN_NODE_LAYER_1 = 32,
  parameter int NUMBER_OF_HIDDEN_NODE_LAYER_2 = 32,
  parameter int NUMBER_OF_OUTPUT_NODE         = 3
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            i_weight_valid,
  input  logic [LAYER_WIDTH-1:0]          i_weight_layer,
  input  logic [WEIGHT_COUNTER_WIDTH-1:0] i_weight_addr,
  input  logic [DATA_WIDTH-1:0]           i_weight,
  input  logic                            i_rd_en,
  input  logic [LAYER_WIDTH-1:0]          i_rd_layer,
  input  logic [WEIGHT_COUNTER_WIDTH-1:0] i_rd_addr,
  output logic                            o_rd_valid,
  output logic [DATA_WIDTH-1:0]           o_rd_data,
  output logic                            o_load_busy,
  output logic                            o_load_done,
  output logic                            o_weights_ready,
  output logic                            o_load_error
`ifdef WEIGHT_RX_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0]           o_checksum
`endif
);

  localparam int CW  = WEIGHT_COUNTER_WIDTH;
  // Layer sizes include one bias word per node.
  localparam int SZ1 = NUMBER_OF_HIDDEN_NODE_LAYER_1 * (NUMBER_OF_INPUT_NODE + 1);
  localparam int SZ2 = NUMBER_OF_HIDDEN_NODE_LAYER_2 * (NUMBER_OF_HIDDEN_NODE_LAYER_1 + 1);
  localparam int SZ3 = NUMBER_OF_OUTPUT_NODE * (NUMBER_OF_HIDDEN_NODE_LAYER_2 + 1);
  localparam int AW1 = $clog2(SZ1);
  localparam int AW2 = $clog2(SZ2);
  localparam int AW3 = $clog2(SZ3);

  localparam logic [LAYER_WIDTH-1:0] LAYER_H1  = LAYER_WIDTH'(1);
  localparam logic [LAYER_WIDTH-1:0] LAYER_H2  = LAYER_WIDTH'(2);
  localparam logic [LAYER_WIDTH-1:0] LAYER_OUT = LAYER_WIDTH'(3);

  typedef enum logic [2:0] {S_IDLE, S_L1, S_L2, S_L3, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ready_q, ready_d;
  logic            done_q, done_d;
  logic            error_q, error_d;
  logic            rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic            we_h1, we_h2, we_h3, start;
  logic            addr_ok1, addr_ok2, addr_ok3;

  logic [DATA_WIDTH-1:0] mem_h1 [SZ1];
  logic [DATA_WIDTH-1:0] mem_h2 [SZ2];
  logic [DATA_WIDTH-1:0] mem_h3 [SZ3];

  assign addr_ok1 = i_weight_addr < CW'(SZ1);
  assign addr_ok2 = i_weight_addr < CW'(SZ2);
  assign addr_ok3 = i_weight_addr < CW'(SZ3);

  // Load FSM: accept in-order layer words, count completion, flag errors.
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latches).
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    done_d  = 1'b0;
    error_d = error_q;
    we_h1   = 1'b0;
    we_h2   = 1'b0;
    we_h3   = 1'b0;
    start   = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (i_weight_valid) begin
          if (i_weight_layer == LAYER_H1 && addr_ok1) begin
            start   = 1'b1;
            we_h1   = 1'b1;
            ready_d = 1'b0;
            error_d = 1'b0;
            cnt_d   = CW'(1);
            state_d = S_L1;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      S_L1: begin
        if (i_weight_valid) begin
          if (i_weight_layer == LAYER_H1 && addr_ok1) begin
            we_h1 = 1'b1;
            if (cnt_q == CW'(SZ1 - 1)) begin
              cnt_d   = '0;
              state_d = S_L2;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            error_d = 1'b1;
          end
        end
      end
      S_L2: begin
        if (i_weight_valid) begin
          if (i_weight_layer == LAYER_H2 && addr_ok2) begin
            we_h2 = 1'b1;
            if (cnt_q == CW'(SZ2 - 1)) begin
              cnt_d   = '0;
              state_d = S_L3;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            error_d = 1'b1;
          end
        end
      end
      S_L3: begin
        if (i_weight_valid) begin
          if (i_weight_layer == LAYER_OUT && addr_ok3) begin
            we_h3 = 1'b1;
            if (cnt_q == CW'(SZ3 - 1)) begin
              cnt_d   = '0;
              state_d = S_DONE;
              done_d  = 1'b1;
              ready_d = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            error_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Read mux: out-of-range or idle-layer reads return zero; hold data when idle.
  always_comb begin
    rd_valid_d = i_rd_en;
    rd_data_d  = rd_data_q;
    if (i_rd_en) begin
      rd_data_d = '0;
      case (i_rd_layer)
        LAYER_H1:  if (i_rd_addr < CW'(SZ1)) rd_data_d = mem_h1[i_rd_addr[AW1-1:0]];
        LAYER_H2:  if (i_rd_addr < CW'(SZ2)) rd_data_d = mem_h2[i_rd_addr[AW2-1:0]];
        LAYER_OUT: if (i_rd_addr < CW'(SZ3)) rd_data_d = mem_h3[i_rd_addr[AW3-1:0]];
        default:   rd_data_d = '0;
      endcase
    end
  end

  // Control and read-port registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all flops update together.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      error_q    <= error_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Weight RAM writes; a same-cycle read sees the old word (read-first).
  always_ff @(posedge clk) begin
    // NOTE: RAM contents are deliberately not reset; ready gates their use.
    if (we_h1) mem_h1[i_weight_addr[AW1-1:0]] <= i_weight;
    if (we_h2) mem_h2[i_weight_addr[AW2-1:0]] <= i_weight;
    if (we_h3) mem_h3[i_weight_addr[AW3-1:0]] <= i_weight;
  end

`ifdef WEIGHT_RX_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] checksum_q, checksum_d;

  // Running XOR of accepted words, restarted by each load start.
  always_comb begin
    checksum_d = checksum_q;
    if (start) begin
      checksum_d = i_weight;
    end else if (we_h1 || we_h2 || we_h3) begin
      checksum_d = checksum_q ^ i_weight;
    end
  end

  // Checksum register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) checksum_q <= '0;
    else        checksum_q <= checksum_d;
  end

  assign o_checksum = checksum_q;
`endif

  assign o_load_busy     = (state_q == S_L1) || (state_q == S_L2) || (state_q == S_L3);
  assign o_load_done     = done_q;
  assign o_weights_ready = ready_q;
  assign o_load_error    = error_q;
  assign o_rd_valid      = rd_valid_q;
  assign o_rd_data       = rd_data_q;

endmodule

// File: tb/tb_weight_load_receiver.sv
// Self-checking bench for weight_load_receiver: full loads, read-back table,
// protocol errors, mid-load reset and (with WEIGHT_RX_CHECKSUM_EN) checksum.
module tb_weight_load_receiver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_weight_valid = 1'b0;
  logic [1:0]  i_weight_layer = '0;
  logic [10:0] i_weight_addr = '0;
  logic [31:0] i_weight = '0;
  logic        i_rd_en = 1'b0;
  logic [1:0]  i_rd_layer = '0;
  logic [10:0] i_rd_addr = '0;
  logic        o_rd_valid, o_load_busy, o_load_done, o_weights_ready, o_load_error;
  logic [31:0] o_rd_data;
`ifdef WEIGHT_RX_CHECKSUM_EN
  logic [31:0] o_checksum;
`endif

  int tests = 0;
  int fails = 0;
  int busy_bad = 0;
  int done_cnt = 0;
  int loads_done = 0;
  bit cks_mode = 1'b0;

  always #5 clk = ~clk;

  weight_load_receiver dut (
    .clk(clk), .rst_n(rst_n),
    .i_weight_valid(i_weight_valid), .i_weight_layer(i_weight_layer),
    .i_weight_addr(i_weight_addr), .i_weight(i_weight),
    .i_rd_en(i_rd_en), .i_rd_layer(i_rd_layer), .i_rd_addr(i_rd_addr),
    .o_rd_valid(o_rd_valid), .o_rd_data(o_rd_data),
    .o_load_busy(o_load_busy), .o_load_done(o_load_done),
    .o_weights_ready(o_weights_ready), .o_load_error(o_load_error)
`ifdef WEIGHT_RX_CHECKSUM_EN
    , .o_checksum(o_checksum)
`endif
  );

  // Count done pulses away from the active edge.
  always @(negedge clk) if (o_load_done) done_cnt++;

  typedef struct {
    logic [1:0]  layer;
    logic [10:0] addr;
    logic [31:0] exp;
  } rd_vec_t;

  rd_vec_t rvec [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Stimulus word for (layer, addr); checksum mode loads 1.0 and 2.0 then zeros.
  function automatic logic [31:0] wval(input logic [1:0] l, input logic [10:0] a);
    if (cks_mode) begin
      if (l == 2'd1 && a == 11'd0) return 32'h3F80_0000;
      if (l == 2'd1 && a == 11'd1) return 32'h4000_0000;
      return 32'h0;
    end
    return {8'h5A, 6'b0, l, 5'b0, a};
  endfunction

  task automatic put_word(input logic [1:0] l, input logic [10:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    i_weight_valid = 1'b1;
    i_weight_layer = l;
    i_weight_addr  = a;
    i_weight       = d;
  endtask

  // Stream addresses [a0, a1) of a layer; busy must hold once the previous word landed.
  task automatic load_range(input logic [1:0] l, input int a0, input int a1, input bit chk_first);
    for (int a = a0; a < a1; a++) begin
      put_word(l, 11'(a), wval(l, 11'(a)));
      if ((a != a0 || chk_first) && !o_load_busy) busy_bad++;
    end
  endtask

  // Capture the last word and check the done pulse and ready level.
  task automatic end_load(input string tag);
    @(posedge clk); #1;
    i_weight_valid = 1'b0;
    loads_done++;
    check({tag, "_done_pulse"}, {31'b0, o_load_done}, 32'd1);
    check({tag, "_ready"}, {31'b0, o_weights_ready}, 32'd1);
    check({tag, "_busy_low"}, {31'b0, o_load_busy}, 32'd0);
    @(posedge clk); #1;
    check({tag, "_done_one_cycle"}, {31'b0, o_load_done}, 32'd0);
    check({tag, "_busy_during_load"}, busy_bad, 32'd0);
  endtask

  task automatic do_read(input string name, input logic [1:0] l, input logic [10:0] a,
                         input logic [31:0] exp);
    @(posedge clk); #1;
    i_rd_en = 1'b1; i_rd_layer = l; i_rd_addr = a;
    @(posedge clk); #1;
    i_rd_en = 1'b0;
    check({name, "_valid"}, {31'b0, o_rd_valid}, 32'd1);
    check({name, "_data"}, o_rd_data, exp);
  endtask

  initial begin
    rvec[0] = '{2'd1, 11'd0,    32'h5A01_0000};
    rvec[1] = '{2'd2, 11'd1055, 32'h5A02_041F};
    rvec[2] = '{2'd3, 11'd98,   32'h5A03_0062};
    rvec[3] = '{2'd0, 11'd5,    32'h0000_0000};
    rvec[4] = '{2'd1, 11'd95,   32'h5A01_005F};
    rvec[5] = '{2'd1, 11'd96,   32'h0000_0000};
    rvec[6] = '{2'd2, 11'd1056, 32'h0000_0000};
    rvec[7] = '{2'd3, 11'd99,   32'h0000_0000};
    rvec[8] = '{2'd2, 11'd500,  32'h5A02_01F4};
    rvec[9] = '{2'd3, 11'd0,    32'h5A03_0000};

    // Reset state.
    #23;
    check("rst_busy", {31'b0, o_load_busy}, 32'd0);
    check("rst_done", {31'b0, o_load_done}, 32'd0);
    check("rst_ready", {31'b0, o_weights_ready}, 32'd0);
    check("rst_error", {31'b0, o_load_error}, 32'd0);
    check("rst_rd_valid", {31'b0, o_rd_valid}, 32'd0);
    check("rst_rd_data", o_rd_data, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Clean full load of 96 + 1056 + 99 words.
    load_range(2'd1, 0, 96, 1'b0);
    load_range(2'd2, 0, 1056, 1'b1);
    load_range(2'd3, 0, 99, 1'b1);
    end_load("loadA");
    check("loadA_error", {31'b0, o_load_error}, 32'd0);

    // Read-back table, including zero returns for layer 00 and out-of-range.
    for (int i = 0; i < 10; i++)
      do_read($sformatf("rd%0d", i), rvec[i].layer, rvec[i].addr, rvec[i].exp);
    @(posedge clk); #1;
    check("rd_valid_idle", {31'b0, o_rd_valid}, 32'd0);

    // Wrong layer in L1 raises sticky error; dropped word in L3 leaves RAM intact.
    put_word(2'd1, 11'd0, wval(2'd1, 11'd0));
    put_word(2'd2, 11'd0, 32'hDEAD_BEEF);
    check("loadB_ready_cleared", {31'b0, o_weights_ready}, 32'd0);
    check("loadB_error_before", {31'b0, o_load_error}, 32'd0);
    put_word(2'd1, 11'd1, wval(2'd1, 11'd1));
    check("loadB_error_wrong_layer", {31'b0, o_load_error}, 32'd1);
    check("loadB_busy_after_error", {31'b0, o_load_busy}, 32'd1);
    load_range(2'd1, 2, 96, 1'b1);
    load_range(2'd2, 0, 1056, 1'b1);
    load_range(2'd3, 0, 50, 1'b1);
    put_word(2'd1, 11'd0, 32'hDEAD_BEEF);
    load_range(2'd3, 50, 99, 1'b1);
    end_load("loadB");
    check("loadB_error_sticky", {31'b0, o_load_error}, 32'd1);
    do_read("loadB_drop", 2'd1, 11'd0, 32'h5A01_0000);

    // Restart from DONE clears error; out-of-range addr does not advance the count.
    put_word(2'd1, 11'd0, wval(2'd1, 11'd0));
    put_word(2'd1, 11'd1, wval(2'd1, 11'd1));
    check("loadC_error_cleared", {31'b0, o_load_error}, 32'd0);
    load_range(2'd1, 2, 40, 1'b1);
    put_word(2'd1, 11'd96, 32'hBAD0_0096);
    put_word(2'd1, 11'd40, wval(2'd1, 11'd40));
    check("loadC_error_addr", {31'b0, o_load_error}, 32'd1);
    load_range(2'd1, 41, 96, 1'b1);
    load_range(2'd2, 0, 1056, 1'b1);
    load_range(2'd3, 0, 99, 1'b1);
    end_load("loadC");

    // Reset after 500 hidden2 words: back to idle, no done pulse.
    load_range(2'd1, 0, 96, 1'b0);
    load_range(2'd2, 0, 500, 1'b1);
    @(posedge clk); #1;
    i_weight_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'b0, o_load_busy}, 32'd0);
    check("midrst_ready", {31'b0, o_weights_ready}, 32'd0);
    check("midrst_error", {31'b0, o_load_error}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("midrst_no_done", done_cnt, loads_done);

    // Non-01 layer while idle is an error and does not start a load.
    put_word(2'd2, 11'd0, 32'h1234_5678);
    @(posedge clk); #1;
    i_weight_valid = 1'b0;
    check("idle_error", {31'b0, o_load_error}, 32'd1);
    check("idle_busy", {31'b0, o_load_busy}, 32'd0);

    // Reload from L1 after the reset.
    load_range(2'd1, 0, 96, 1'b0);
    load_range(2'd2, 0, 1056, 1'b1);
    load_range(2'd3, 0, 99, 1'b1);
    end_load("reload");
    check("reload_error", {31'b0, o_load_error}, 32'd0);
    do_read("reload_rd", 2'd2, 11'd1000, 32'h5A02_03E8);

`ifdef WEIGHT_RX_CHECKSUM_EN
    // 0x3F800000 ^ 0x40000000 with all other words zero.
    cks_mode = 1'b1;
    load_range(2'd1, 0, 96, 1'b0);
    load_range(2'd2, 0, 1056, 1'b1);
    load_range(2'd3, 0, 99, 1'b1);
    end_load("cks");
    check("cks_value", o_checksum, 32'h7F80_0000);
    repeat (3) @(posedge clk);
    #1;
    check("cks_held", o_checksum, 32'h7F80_0000);
`endif

    check("done_pulse_count", done_cnt, loads_done);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
